// File: rtl/alu_pkg.sv
// alu_pkg: definitions shared by the datapath ALU and its board front-end.
// Contents: default opcode width, ALU opcodes, flag vector width and bit
// positions, and the chunk-select code that requests result chaining.
package alu_pkg;

  localparam int OP_W = 8;

  localparam logic [OP_W-1:0] OP_ADD  = 8'h00;
  localparam logic [OP_W-1:0] OP_SUB  = 8'h01;
  localparam logic [OP_W-1:0] OP_AND  = 8'h02;
  localparam logic [OP_W-1:0] OP_OR   = 8'h03;
  localparam logic [OP_W-1:0] OP_XOR  = 8'h04;
  localparam logic [OP_W-1:0] OP_SHL  = 8'h05;
  localparam logic [OP_W-1:0] OP_SHR  = 8'h06;
  localparam logic [OP_W-1:0] OP_PASS = 8'h07;

  localparam int FLAG_W = 5;
  localparam int FLAG_C = 0;  // carry / borrow
  localparam int FLAG_Z = 1;  // zero
  localparam int FLAG_N = 2;  // negative
  localparam int FLAG_V = 3;  // signed overflow
  localparam int FLAG_P = 4;  // parity

  localparam int SEL_W = 2;
  localparam logic [SEL_W-1:0] SEL_RESULT = 2'b11;

  // Number of byte chunks that make up an operand of width w.
  function automatic int num_bytes(input int w);
    return w / 8;
  endfunction

endpackage

// File: rtl/alu_board_ctrl_button_cond.sv
// button_cond: conditions one raw push-button into a single-cycle press pulse.
// A 2-FF synchronizer feeds an optional counter debouncer, followed by a
// rising-edge detector on the (debounced) level.
// Ports: clk, rst_n (async active-low), raw (asynchronous button),
//        pulse (one clk cycle high per recognised press).
// Parameters: DEB_EN selects the debouncer, DEB_CYCLES is the number of
//             consecutive differing samples needed to flip the level.
module button_cond #(
  parameter bit DEB_EN     = 1'b0,
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic pulse
);

  logic sync1, sync2;
  logic level, level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  generate
    if (DEB_EN) begin : g_deb
      localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
      logic [CW-1:0] cnt;
      logic          deb;

      // Count consecutive samples that disagree with the current level;
      // any agreeing sample restarts the count.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
          deb <= 1'b0;
        end else if (sync2 != deb) begin
          if (cnt == CW'(DEB_CYCLES - 1)) begin
            deb <= sync2;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end

      assign level = deb;
    end else begin : g_nodeb
      assign level = sync2;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 1'b0;
    else        level_q <= level;
  end

  // Combinational so the load lands one edge after the level rises.
  assign pulse = level & ~level_q;

endmodule

// File: rtl/hexTo7Seg.sv
// hexTo7Seg: one hex nibble to an active-high seven-segment pattern.
// Ports: hex (4-bit nibble in), seg (7-bit pattern out, bit order gfedcba).
module hexTo7Seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/alu_board_ctrl.sv
// alu_board_ctrl: board front-end for the datapath ALU.
// Debounces the A/B/Op buttons, assembles operands byte-wise from the slide
// switches, issues registered execute requests and latches result/flags for
// the four seven-segment digits.
// Ports: clk, rst_n (async active-low); A_button, B_button, Op_button, cin,
//        data_in[9:0] (raw board inputs); alu_a, alu_b, alu_op, alu_cin
//        (registered ALU inputs); alu_result, alu_flags (ALU outputs);
//        result, Flags, done (latched outputs); Hex_output_1..4 (digits for
//        result[15:12] .. result[3:0]).
// Build option: define ALU_CTRL_DEBOUNCE_EN to enable the counter debouncer.
module alu_board_ctrl #(
  parameter int DATA_W     = 16,
  parameter int OP_W       = alu_pkg::OP_W,
  parameter int DEB_CYCLES = 250000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      A_button,
  input  logic                      B_button,
  input  logic                      Op_button,
  input  logic                      cin,
  input  logic [9:0]                data_in,
  output logic [DATA_W-1:0]         alu_a,
  output logic [DATA_W-1:0]         alu_b,
  output logic [OP_W-1:0]           alu_op,
  output logic                      alu_cin,
  input  logic [DATA_W-1:0]         alu_result,
  input  logic [alu_pkg::FLAG_W-1:0] alu_flags,
  output logic [DATA_W-1:0]         result,
  output logic [alu_pkg::FLAG_W-1:0] Flags,
  output logic                      done,
  output logic [6:0]                Hex_output_1,
  output logic [6:0]                Hex_output_2,
  output logic [6:0]                Hex_output_3,
  output logic [6:0]                Hex_output_4
);

  import alu_pkg::*;

`ifdef ALU_CTRL_DEBOUNCE_EN
  localparam bit DEB_EN = 1'b1;
`else
  localparam bit DEB_EN = 1'b0;
`endif

  localparam int NB   = num_bytes(DATA_W);
  localparam int OP_CP = (OP_W < 10) ? OP_W : 10;

  logic a_pulse, b_pulse, op_pulse;
  logic cin_s1, cin_s;
  logic [9:0] data_s1, data_s;
  logic [SEL_W-1:0] sel;
  logic [7:0] byte_val;
  logic [OP_W-1:0] op_next;
  logic exec_pend;

  button_cond #(.DEB_EN(DEB_EN), .DEB_CYCLES(DEB_CYCLES)) u_btn_a (
    .clk(clk), .rst_n(rst_n), .raw(A_button), .pulse(a_pulse)
  );
  button_cond #(.DEB_EN(DEB_EN), .DEB_CYCLES(DEB_CYCLES)) u_btn_b (
    .clk(clk), .rst_n(rst_n), .raw(B_button), .pulse(b_pulse)
  );
  button_cond #(.DEB_EN(DEB_EN), .DEB_CYCLES(DEB_CYCLES)) u_btn_op (
    .clk(clk), .rst_n(rst_n), .raw(Op_button), .pulse(op_pulse)
  );

  // Switches get the same two-stage delay as the buttons, so data set up
  // before a press is already settled when the press pulse arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cin_s1  <= 1'b0;
      cin_s   <= 1'b0;
      data_s1 <= '0;
      data_s  <= '0;
    end else begin
      cin_s1  <= cin;
      cin_s   <= cin_s1;
      data_s1 <= data_in;
      data_s  <= data_s1;
    end
  end

  assign sel      = data_s[9:8];
  assign byte_val = data_s[7:0];

  always_comb begin
    op_next = '0;
    op_next[OP_CP-1:0] = data_s[OP_CP-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      alu_cin   <= 1'b0;
      result    <= '0;
      Flags     <= '0;
      done      <= 1'b0;
      exec_pend <= 1'b0;
    end else begin
      // A second Op pulse on the execute cycle simply re-arms execute.
      exec_pend <= op_pulse;
      done      <= exec_pend;
      if (exec_pend) begin
        result <= alu_result;
        Flags  <= alu_flags;
      end

      if (a_pulse) begin
        if (sel == SEL_RESULT) begin
          alu_a <= result;
        end else begin
          for (int i = 0; i < NB; i++) begin
            if (sel == SEL_W'(i)) alu_a[i*8 +: 8] <= byte_val;
          end
        end
      end

      if (b_pulse) begin
        if (sel == SEL_RESULT) begin
          alu_b <= result;
        end else begin
          for (int i = 0; i < NB; i++) begin
            if (sel == SEL_W'(i)) alu_b[i*8 +: 8] <= byte_val;
          end
        end
      end

      if (op_pulse) begin
        alu_op  <= op_next;
        alu_cin <= cin_s;
      end
    end
  end

  // Digits always show 16 bits; narrower results are zero-padded on top.
  logic [15:0] result16;
  generate
    if (DATA_W >= 16) begin : g_wide
      assign result16 = result[15:0];
    end else begin : g_narrow
      assign result16 = {8'h00, result[7:0]};
    end
  endgenerate

  hexTo7Seg u_hex1 (.hex(result16[15:12]), .seg(Hex_output_1));
  hexTo7Seg u_hex2 (.hex(result16[11:8]),  .seg(Hex_output_2));
  hexTo7Seg u_hex3 (.hex(result16[7:4]),   .seg(Hex_output_3));
  hexTo7Seg u_hex4 (.hex(result16[3:0]),   .seg(Hex_output_4));

endmodule
